// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter
//   Owns the single write port of the FPGA register file. After reset (or on
//   init_req_i) it scrubs registers 1..NUM-1 with InitVal, then arbitrates
//   between two writeback requesters:
//     A - execute-stage result, default priority
//     B - load/store result, wins after MaxWait consecutive denied cycles
//   Ports:
//     clk_i, rst_i          clock, asynchronous active-high reset
//     init_req_i            restart scrub (sampled only while arbitrating)
//     busy_o                high while scrubbing
//     a_req/addr/data_i     requester A write request, a_gnt_o same-cycle grant
//     b_req/addr/data_i     requester B write request, b_gnt_o same-cycle grant
//     waddr_o/wdata_o/we_o  registered register-file write port
module ibex_rf_wb_arbiter #(
  parameter bit                   RV32E     = 1'b0,
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] InitVal   = '0,
  parameter int unsigned          MaxWait   = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_req_i,
  output logic                 busy_o,
  input  logic                 a_req_i,
  input  logic [4:0]           a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  output logic                 a_gnt_o,
  input  logic                 b_req_i,
  input  logic [4:0]           b_addr_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic                 b_gnt_o,
  output logic [4:0]           waddr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 we_o
);

  localparam logic [4:0] LastReg   = RV32E ? 5'd15 : 5'd31;
  localparam logic [3:0] MaxWaitC  = 4'(MaxWait);

  typedef enum logic {
    StInit,
    StArb
  } state_e;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic [4:0]             waddr_q, waddr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;

  logic                   b_prio;
  logic [4:0]             sel_addr;
  logic [DataWidth-1:0]   sel_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    a_gnt_o    = 1'b0;
    b_gnt_o    = 1'b0;
    b_prio     = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;

    unique case (state_q)
      StInit: begin
        // Register 0 is skipped: cnt starts at 1 and wraps back to 1.
        waddr_d = cnt_q;
        wdata_d = InitVal;
        we_d    = 1'b1;
        if (cnt_q == LastReg) begin
          state_d = StArb;
          cnt_d   = 5'd1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      StArb: begin
        if (init_req_i) begin
          state_d = StInit;
        end else begin
          b_prio = (wait_cnt_q == MaxWaitC);
          if (b_req_i && (b_prio || !a_req_i)) begin
            b_gnt_o = 1'b1;
          end else if (a_req_i) begin
            a_gnt_o = 1'b1;
          end

          if (b_gnt_o) begin
            sel_addr = b_addr_i;
            sel_data = b_data_i;
          end else begin
            sel_addr = a_addr_i;
            sel_data = a_data_i;
          end

          // Writes to x0 (and x16..x31 on RV32E) are accepted but dropped.
          if (a_gnt_o || b_gnt_o) begin
            waddr_d = sel_addr;
            wdata_d = sel_data;
            we_d    = (sel_addr != 5'd0) && !(RV32E && sel_addr[4]);
          end

          if (b_req_i && !b_gnt_o) begin
            if (wait_cnt_q != MaxWaitC) begin
              wait_cnt_d = wait_cnt_q + 4'd1;
            end
          end else begin
            wait_cnt_d = '0;
          end
        end
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      cnt_q      <= 5'd1;
      wait_cnt_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  assign busy_o  = (state_q == StInit);
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Testbench for ibex_rf_wb_arbiter. Instance 0 is RV32I (MaxWait=3,
// InitVal=DEADBEEF), instance 1 is RV32E (MaxWait=2, InitVal=E5). Both are
// stepped together against a per-instance behavioural model.
module tb_ibex_rf_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       init_req, a_req, b_req;
  logic [1:0][4:0]  a_addr, b_addr;
  logic [1:0][31:0] a_data, b_data;
  logic [1:0]       busy, a_gnt, b_gnt, we;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(
    .RV32E(1'b0), .DataWidth(32), .InitVal(32'hDEAD_BEEF), .MaxWait(3)
  ) u_dut_i (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req[0]), .busy_o(busy[0]),
    .a_req_i(a_req[0]), .a_addr_i(a_addr[0]), .a_data_i(a_data[0]), .a_gnt_o(a_gnt[0]),
    .b_req_i(b_req[0]), .b_addr_i(b_addr[0]), .b_data_i(b_data[0]), .b_gnt_o(b_gnt[0]),
    .waddr_o(waddr[0]), .wdata_o(wdata[0]), .we_o(we[0])
  );

  ibex_rf_wb_arbiter #(
    .RV32E(1'b1), .DataWidth(32), .InitVal(32'h0000_00E5), .MaxWait(2)
  ) u_dut_e (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req[1]), .busy_o(busy[1]),
    .a_req_i(a_req[1]), .a_addr_i(a_addr[1]), .a_data_i(a_data[1]), .a_gnt_o(a_gnt[1]),
    .b_req_i(b_req[1]), .b_addr_i(b_addr[1]), .b_data_i(b_data[1]), .b_gnt_o(b_gnt[1]),
    .waddr_o(waddr[1]), .wdata_o(wdata[1]), .we_o(we[1])
  );

  // Reference model: scrub progress as a register index, B starvation as a
  // plain count of consecutive denied cycles.
  typedef struct {
    bit          scrubbing;
    int          next_reg;
    int          denied;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          we;
  } mdl_t;

  mdl_t        m [2];
  int          num  [2] = '{32, 16};
  int          maxw [2] = '{3, 2};
  logic [31:0] ival [2] = '{32'hDEAD_BEEF, 32'h0000_00E5};
  bit          exp_ga [2];
  bit          exp_gb [2];
  logic [1:0]  s_agnt, s_bgnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].scrubbing = 1'b1;
      m[i].next_reg  = 1;
      m[i].denied    = 0;
      m[i].waddr     = '0;
      m[i].wdata     = '0;
      m[i].we        = 1'b0;
    end
  endtask

  task automatic model_grant(input int i, output bit ga, output bit gb);
    ga = 1'b0;
    gb = 1'b0;
    if (!m[i].scrubbing && !init_req[i]) begin
      if (b_req[i] && (m[i].denied >= maxw[i] || !a_req[i])) gb = 1'b1;
      else if (a_req[i]) ga = 1'b1;
    end
  endtask

  task automatic model_edge(input int i, input bit ga, input bit gb);
    int addr;
    if (m[i].scrubbing) begin
      m[i].waddr = 5'(m[i].next_reg);
      m[i].wdata = ival[i];
      m[i].we    = 1'b1;
      if (m[i].next_reg == num[i] - 1) begin
        m[i].scrubbing = 1'b0;
        m[i].next_reg  = 1;
      end else begin
        m[i].next_reg++;
      end
    end else if (init_req[i]) begin
      m[i].we        = 1'b0;
      m[i].scrubbing = 1'b1;
    end else begin
      if (ga || gb) begin
        addr       = gb ? int'(b_addr[i]) : int'(a_addr[i]);
        m[i].waddr = 5'(addr);
        m[i].wdata = gb ? b_data[i] : a_data[i];
        m[i].we    = (addr != 0) && (addr < num[i]);
      end else begin
        m[i].we = 1'b0;
      end
      if (b_req[i] && !gb) m[i].denied++;
      else m[i].denied = 0;
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic step();
    #2;
    for (int i = 0; i < 2; i++) begin
      model_grant(i, exp_ga[i], exp_gb[i]);
      check_eq($sformatf("a_gnt[%0d]", i), 32'(a_gnt[i]), 32'(exp_ga[i]));
      check_eq($sformatf("b_gnt[%0d]", i), 32'(b_gnt[i]), 32'(exp_gb[i]));
      check_eq($sformatf("busy[%0d]", i),  32'(busy[i]),  32'(m[i].scrubbing));
    end
    s_agnt = a_gnt;
    s_bgnt = b_gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      model_edge(i, exp_ga[i], exp_gb[i]);
      check_eq($sformatf("we[%0d]", i), 32'(we[i]), 32'(m[i].we));
      if (m[i].we) begin
        check_eq($sformatf("waddr[%0d]", i), 32'(waddr[i]), 32'(m[i].waddr));
        check_eq($sformatf("wdata[%0d]", i), wdata[i], m[i].wdata);
      end
    end
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_we[%0d]", i),    32'(we[i]),    32'd0);
      check_eq($sformatf("rst_waddr[%0d]", i), 32'(waddr[i]), 32'd0);
      check_eq($sformatf("rst_wdata[%0d]", i), wdata[i],      32'd0);
      check_eq($sformatf("rst_busy[%0d]", i),  32'(busy[i]),  32'd1);
      check_eq($sformatf("rst_gnt[%0d]", i),   32'({a_gnt[i], b_gnt[i]}), 32'd0);
    end
  endtask

  // Requesters hold req/addr/data until granted, then maybe issue a new one.
  task automatic rand_inputs(input int i);
    if (a_req[i] && exp_ga[i]) a_req[i] = 1'b0;
    if (b_req[i] && exp_gb[i]) b_req[i] = 1'b0;
    if (!a_req[i] && $urandom_range(0, 3) != 0) begin
      a_req[i]  = 1'b1;
      a_addr[i] = 5'($urandom);
      a_data[i] = $urandom;
    end
    if (!b_req[i] && $urandom_range(0, 2) == 0) begin
      b_req[i]  = 1'b1;
      b_addr[i] = 5'($urandom);
      b_data[i] = $urandom;
    end
    init_req[i] = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    int  n;
    bit  found;
    init_req = '0; a_req = '0; b_req = '0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    exp_ga = '{1'b0, 1'b0};
    exp_gb = '{1'b0, 1'b0};

    #1 rst = 1'b1;
    #1 check_reset_vals();
    model_reset();
    rst = 1'b0;

    // Reset scrub: cycle 0 then edges 1..31.
    step();
    for (int k = 1; k < 31; k++) begin
      check_eq("scrub_addr_i", 32'(waddr[0]), 32'(k));
      if (k < 16) check_eq("scrub_addr_e", 32'(waddr[1]), 32'(k));
      step();
    end
    check_eq("scrub_last_i", 32'(waddr[0]), 32'd31);
    check_eq("scrub_done_busy_i", 32'(busy[0]), 32'd0);

    // Simultaneous requests: A first, B next cycle.
    a_req[0] = 1'b1; a_addr[0] = 5'd5; a_data[0] = 32'h1111;
    b_req[0] = 1'b1; b_addr[0] = 5'd6; b_data[0] = 32'h2222;
    step();
    check_eq("sim_a_gnt", 32'(s_agnt[0]), 32'd1);
    check_eq("sim_a_write", {we[0], 26'd0, waddr[0]}, {1'b1, 26'd0, 5'd5});
    a_req[0] = 1'b0;
    step();
    check_eq("sim_b_gnt", 32'(s_bgnt[0]), 32'd1);
    check_eq("sim_b_data", wdata[0], 32'h2222);
    b_req[0] = 1'b0;
    step();

    // Starvation: A continuously, B on x7 granted in its 4th cycle.
    a_req[0] = 1'b1; a_addr[0] = 5'd3; a_data[0] = 32'hA0;
    b_req[0] = 1'b1; b_addr[0] = 5'd7; b_data[0] = 32'h7777;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      n++;
      if (s_bgnt[0]) break;
      a_data[0] = a_data[0] + 1;
    end
    check_eq("starve_cycles", 32'(n), 32'd4);
    check_eq("starve_a_off", 32'(s_agnt[0]), 32'd0);
    b_req[0] = 1'b0;
    step();
    // B re-requests against A again: window restarts from zero.
    b_req[0] = 1'b1; b_addr[0] = 5'd8;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      n++;
      if (s_bgnt[0]) break;
    end
    check_eq("starve_again_cycles", 32'(n), 32'd4);
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    step();

    // x0 drop on RV32I, x17 drop on RV32E.
    a_req = 2'b11; a_addr[0] = 5'd0; a_addr[1] = 5'd17;
    a_data[0] = 32'h55; a_data[1] = 32'h66;
    step();
    check_eq("x0_gnt", 32'(s_agnt[0]), 32'd1);
    check_eq("x0_we", 32'(we[0]), 32'd0);
    check_eq("x17_gnt", 32'(s_agnt[1]), 32'd1);
    check_eq("x17_we", 32'(we[1]), 32'd0);
    a_addr[1] = 5'd3;
    a_req[0] = 1'b0;
    step();
    check_eq("e_x3_we", 32'(we[1]), 32'd1);
    a_req[1] = 1'b0;

    // init_req collides with an A request.
    init_req[0] = 1'b1; a_req[0] = 1'b1; a_addr[0] = 5'd9; a_data[0] = 32'h9999;
    step();
    check_eq("init_no_gnt", 32'(s_agnt[0]), 32'd0);
    init_req[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n++;
      if (s_agnt[0]) break;
    end
    check_eq("init_then_a_cycle", 32'(n), 32'd32);
    a_req[0] = 1'b0;

    // Reset in the middle of a scrub at waddr_o == 12.
    init_req[0] = 1'b1;
    step();
    init_req[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (busy[0] && waddr[0] == 5'd12) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("midscrub_seen", 32'(found), 32'd1);
    rst = 1'b1;
    #1 check_reset_vals();
    model_reset();
    rst = 1'b0;
    step();
    check_eq("restart_addr", 32'(waddr[0]), 32'd1);
    check_eq("restart_we", 32'(we[0]), 32'd1);
    for (int c = 0; c < 40 && m[0].scrubbing; c++) step();

    // Randomized traffic on both instances.
    exp_ga = '{1'b0, 1'b0};
    exp_gb = '{1'b0, 1'b0};
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(0);
      rand_inputs(1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
